// File: rtl/serial_link_link_ctrl.sv
// Serial-link bring-up/shutdown controller: sequences link clock, reset and
// AXI isolation through a Moore FSM with a shared per-state cycle counter.
module serial_link_link_ctrl #(
  parameter int ResetCycles   = 16,
  parameter int TimeoutCycles = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       err_clr_i,
  input  logic [1:0] isolated_i,
  output logic [1:0] isolate_o,
  output logic       clk_ena_o,
  output logic       reset_no,
  output logic       link_up_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  localparam int MaxCycles = (ResetCycles > TimeoutCycles) ? ResetCycles : TimeoutCycles;
  localparam int CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] RstLast = CntW'(ResetCycles - 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    RST_HOLD = 3'd1,
    DEISO    = 3'd2,
    UP       = 3'd3,
    ISO      = 3'd4,
    HALT     = 3'd5,
    ERR      = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clk_ena_q, reset_n_q, link_up_q, err_q;
  logic [1:0]      isolate_q;

  // Output bundle {clk_ena, reset_n, isolate[1:0], link_up, err} per state.
  function automatic logic [5:0] decode(input state_e st);
    case (st)
      OFF:      decode = 6'b0_0_11_0_0;
      RST_HOLD: decode = 6'b1_0_11_0_0;
      DEISO:    decode = 6'b1_1_00_0_0;
      UP:       decode = 6'b1_1_00_1_0;
      ISO:      decode = 6'b1_1_11_0_0;
      HALT:     decode = 6'b1_0_11_0_0;
      ERR:      decode = 6'b1_0_11_0_1;
      default:  decode = 6'b0_0_11_0_0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF: begin
        if (start_i && !stop_i) state_d = RST_HOLD;
      end
      RST_HOLD: begin
        if (stop_i)                state_d = HALT;
        else if (cnt_q == RstLast) state_d = DEISO;
      end
      DEISO: begin
        if (stop_i)                    state_d = ISO;
        else if (isolated_i == 2'b00)  state_d = UP;
        else if (cnt_q == TmoLast)     state_d = ERR;
      end
      UP: begin
        if (stop_i)                    state_d = ISO;
        else if (isolated_i != 2'b00)  state_d = ERR;
      end
      ISO: begin
        if (isolated_i == 2'b11)       state_d = HALT;
        else if (cnt_q == TmoLast)     state_d = ERR;
      end
      HALT: begin
        if (cnt_q == RstLast) state_d = OFF;
      end
      ERR: begin
        if (err_clr_i) state_d = OFF;
      end
      default: state_d = OFF;
    endcase
  end

  // Counter restarts on each state entry and saturates rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      clk_ena_q <= 1'b0;
      reset_n_q <= 1'b0;
      isolate_q <= 2'b11;
      link_up_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      {clk_ena_q, reset_n_q, isolate_q, link_up_q, err_q} <= decode(state_d);
    end
  end

  assign clk_ena_o = clk_ena_q;
  assign reset_no  = reset_n_q;
  assign isolate_o = isolate_q;
  assign link_up_o = link_up_q;
  assign err_o     = err_q;
  assign state_o   = state_q;

endmodule
